// File: rtl/draw_rect_if.sv
// VGA pipeline bus: raster timing plus pixel colour for one pixel per cycle.
//   hcount/vcount : 11 b pixel position
//   hsync/vsync   : sync pulses
//   hblnk/vblnk   : blanking flags
//   rgb           : 12 b colour {r[3:0], g[3:0], b[3:0]}
// The "out" modport is the producer side and the "in" modport is the consumer side.
// master/slave are the same two views under their generic names.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport out    (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport in     (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect.sv
// draw_rect: overlays a RECT_WIDTH x RECT_HEIGHT image from an external ROM onto the
// background stream of the 1024x768 VGA chain.
//   clk65MHz     : pixel clock, rising edge
//   rst          : synchronous, active-high reset
//   bg_if        : upstream timing + background rgb
//   draw_rect_if : same fields delayed by 2 cycles, rgb replaced inside the rectangle
//   xpos/ypos    : requested top-left corner, sampled once per frame
//   pixel_addr   : image ROM address {row[5:0], col[5:0]}, registered
//   rgb_pixel    : ROM data for pixel_addr, consumed on the edge after pixel_addr updates
module draw_rect #(
  parameter int unsigned RECT_WIDTH  = 48,
  parameter int unsigned RECT_HEIGHT = 64
) (
  input  logic        clk65MHz,
  input  logic        rst,
  vga_if.in           bg_if,
  vga_if.out          draw_rect_if,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  output logic [11:0] pixel_addr,
  input  logic [11:0] rgb_pixel
);

  // Per-frame position latch.
  logic [11:0] x_l, y_l;
  logic        vblnk_prev;

  // Stage-1 registers.
  logic [10:0] hcount_1, vcount_1;
  logic        hsync_1, vsync_1, hblnk_1, vblnk_1;
  logic [11:0] rgb_1;
  logic        in_rect_1;

  // Stage-1 decode, 13 b wide so x_l + RECT_WIDTH cannot wrap.
  logic [12:0] h13, v13, x13, y13, x_end, y_end;
  logic [11:0] dx, dy;
  logic        in_rect_d;
  logic        latch_pos;

  always_comb begin
    h13   = {2'b00, bg_if.hcount};
    v13   = {2'b00, bg_if.vcount};
    x13   = {1'b0, x_l};
    y13   = {1'b0, y_l};
    x_end = x13 + 13'(RECT_WIDTH);
    y_end = y13 + 13'(RECT_HEIGHT);
    // Blanking gates the overlay, so rectangles past the right/bottom edge never
    // reach into the next line or frame.
    in_rect_d = !bg_if.hblnk && !bg_if.vblnk &&
                (h13 >= x13) && (h13 < x_end) &&
                (v13 >= y13) && (v13 < y_end);
    dx = {1'b0, bg_if.hcount} - x_l;
    dy = {1'b0, bg_if.vcount} - y_l;
    // First blanking line of the frame: position is frozen for the whole next frame.
    latch_pos = bg_if.vblnk && !vblnk_prev;
  end

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      x_l        <= '0;
      y_l        <= '0;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= bg_if.vblnk;
      if (latch_pos) begin
        x_l <= xpos;
        y_l <= ypos;
      end
    end
  end

  // Stage 1: register timing, compute rectangle hit and ROM address.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      hcount_1   <= '0;
      vcount_1   <= '0;
      hsync_1    <= 1'b0;
      vsync_1    <= 1'b0;
      hblnk_1    <= 1'b0;
      vblnk_1    <= 1'b0;
      rgb_1      <= '0;
      in_rect_1  <= 1'b0;
      pixel_addr <= '0;
    end else begin
      hcount_1   <= bg_if.hcount;
      vcount_1   <= bg_if.vcount;
      hsync_1    <= bg_if.hsync;
      vsync_1    <= bg_if.vsync;
      hblnk_1    <= bg_if.hblnk;
      vblnk_1    <= bg_if.vblnk;
      rgb_1      <= bg_if.rgb;
      in_rect_1  <= in_rect_d;
      pixel_addr <= {dy[5:0], dx[5:0]};
    end
  end

  // Stage 2: ROM data for the stage-1 address is available here.
  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      draw_rect_if.hcount <= '0;
      draw_rect_if.vcount <= '0;
      draw_rect_if.hsync  <= 1'b0;
      draw_rect_if.vsync  <= 1'b0;
      draw_rect_if.hblnk  <= 1'b0;
      draw_rect_if.vblnk  <= 1'b0;
      draw_rect_if.rgb    <= '0;
    end else begin
      draw_rect_if.hcount <= hcount_1;
      draw_rect_if.vcount <= vcount_1;
      draw_rect_if.hsync  <= hsync_1;
      draw_rect_if.vsync  <= vsync_1;
      draw_rect_if.hblnk  <= hblnk_1;
      draw_rect_if.vblnk  <= vblnk_1;
      draw_rect_if.rgb    <= in_rect_1 ? rgb_pixel : rgb_1;
    end
  end

endmodule

// File: doc/draw_rect.md
# draw_rect

Pipeline stage of the 1024x768 @ 60 Hz VGA chain (65 MHz pixel clock), between the background generator and `draw_mouse`. Overlays a RECT_WIDTH x RECT_HEIGHT image onto the background. The image is read from an external synchronous image ROM. The rectangle's top-left corner is taken from `xpos`/`ypos`, sampled once per frame so the image never tears mid-frame. All timing signals are delayed to stay aligned with the new rgb.

## Interface
- RECT_WIDTH, 48: image width in pixels, 1..64
- RECT_HEIGHT, 64: image height in pixels, 1..64
- clk65MHz  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- bg_if  vga_if.in  -  upstream timing + rgb (hcount/vcount 11 b, hsync/vsync/hblnk/vblnk 1 b, rgb 12 b)
- draw_rect_if  vga_if.out  -  same fields, feeds draw_mouse
- xpos  in  12  requested rectangle left edge, pixels
- ypos  in  12  requested rectangle top edge, pixels
- pixel_addr  out  12  image ROM address {row[5:0], col[5:0]}
- rgb_pixel  in  12  ROM data, valid exactly 1 cycle after pixel_addr

## Operation
- Position latch:
  - x_l/y_l (12 b each) load xpos/ypos on the cycle where bg_if.vblnk is 1 and its registered previous value is 0, i.e. the first blanking line.
  - x_l/y_l hold otherwise; they reset to 0.
  - A position change mid-frame takes effect only in the next frame.
- Stage 1, registered:
  - in_rect_1 = !hblnk && !vblnk && hcount >= x_l && hcount < x_l+RECT_WIDTH && vcount >= y_l && vcount < y_l+RECT_HEIGHT.
  - Comparisons are done in 13 b unsigned, with hcount/vcount zero-extended, so x_l+W never wraps.
  - pixel_addr <= {vcount-y_l, hcount-x_l}, each difference truncated to 6 b. pixel_addr is don't-care when in_rect_1 = 0, but is always driven.
  - All bg_if fields are copied into stage-1 registers.
- Stage 2, registered:
  - All timing fields are copied from stage 1 into draw_rect_if.
  - draw_rect_if.rgb <= in_rect_1 ? rgb_pixel : rgb_1.
- Clipping:
  - A rectangle partly outside 0..1023 / 0..767 shows only its visible part, with no wrap to the opposite edge.
  - x_l >= 1024 or y_l >= 768 gives no overlay.
- Reset: all draw_rect_if fields = 0, pixel_addr = 0, in_rect_1 = 0, stage-1 registers = 0, x_l = y_l = 0, vblnk history = 0.
- Reset asserted mid-frame clears everything on the next edge. Normal operation restarts from the next valid bg_if cycle. No overlay appears before the first latch after reset, except at the reset position (0,0).

## Timing
- Latency bg_if -> draw_rect_if: exactly 2 cycles for every field, hsync/vsync/blank included.
- pixel_addr is valid 1 cycle after the corresponding bg_if sample. The ROM must return data on the following edge; no other ROM latency is supported.
- Position latch: xpos/ypos sampled on the vblnk rising cycle are used from the first active line of the next frame.
- Throughput: 1 pixel per cycle, no stalls, no handshake.

## Test plan
- Reset: hold rst 3 cycles with random bg_if -> all draw_rect_if fields and pixel_addr read 0; 2 cycles after release, outputs equal bg_if delayed by 2.
- Pass-through: xpos=ypos=2000, full frame of background rgb 12'h8_8_8 -> draw_rect_if is bit-exact to bg_if delayed 2 cycles over the entire frame.
- Placement: xpos=100, ypos=200, ROM model returns its address as rgb.
  - At (100,200) output rgb = 12'h000; at (147,263) rgb = {6'd63, 6'd47}.
  - At (148,200) and (100,264) output = background.
- Frame sync: change xpos from 100 to 300 at vcount=400 -> rectangle stays at x=100 for the rest of the frame; at x=300 in the next frame.
- Edge clip: xpos=1000, ypos=750 -> overlay only for hcount 1000..1023 and vcount 750..767; columns 0..23 of lines 751..767 show background.
- Mid-frame reset: assert rst at hcount=500, vcount=300 for 1 cycle -> outputs 0 on the next edge. Resumes 2-cycle-delayed pass-through. Rectangle reappears at the newly latched position the next frame.
